// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the cpu_ctrl control unit.
//
// Holds the FSM state enum, the instruction class enum produced by
// cpu_ctrl_decode, the opcode/op field constants, and the reg_sel and
// wb_sel encodings driven to the datapath.
//
// Configuration macro: CPU_CTRL_TRAP_EN adds the S_TRAP state.

package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_WR_REG,
    S_WR_IMM
`ifdef CPU_CTRL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_MOV_IMM,
    CLS_MOV_REG,
    CLS_ADD,
    CLS_AND,
    CLS_CMP,
    CLS_MVN
  } instr_class_t;

  // instr[15:13]
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // instr[12:11] under OPC_MOV
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

  // instr[12:11] under OPC_ALU
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  // Register-file index source
  localparam logic [1:0] REG_SEL_RM = 2'b00;
  localparam logic [1:0] REG_SEL_RD = 2'b01;
  localparam logic [1:0] REG_SEL_RN = 2'b10;

  // Write-back source
  localparam logic [1:0] WB_SEL_C   = 2'b00;
  localparam logic [1:0] WB_SEL_IMM = 2'b10;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode -- combinational instruction classifier.
//
// Ports:
//   opcode  in  [2:0]  instr[15:13]
//   op      in  [1:0]  instr[12:11]
//   cls     out        instruction class (CLS_ILLEGAL for unsupported pairs)

module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  logic [2:0]   opcode,
  input  logic [1:0]   op,
  output instr_class_t cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OPC_MOV: begin
        if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
        else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
      end
      OPC_ALU: begin
        case (op)
          OP_ADD:  cls = CLS_ADD;
          OP_CMP:  cls = CLS_CMP;
          OP_AND:  cls = CLS_AND;
          default: cls = CLS_MVN;
        endcase
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl -- multi-cycle control FSM for a simple register/ALU datapath.
//
// Ports:
//   clk        in        single clock, rising edge
//   rst        in        synchronous active-high reset (priority over start)
//   start      in        begin executing the held instruction (sampled in WAIT)
//   opcode     in  [2:0] instr[15:13]
//   op         in  [1:0] instr[12:11]
//   waiting    out       high only in WAIT
//   reg_sel    out [1:0] register index source (00 Rm, 01 Rd, 10 Rn)
//   wb_sel     out [1:0] write-back source (00 datapath C, 10 sign-ext imm8)
//   w_en, en_A, en_B, en_C, en_status  out  write / load enables
//   sel_A      out       force ALU A operand to zero
//   illegal    out       sticky illegal-opcode flag (CPU_CTRL_TRAP_EN only)
//
// Configuration macro: CPU_CTRL_TRAP_EN -- illegal instructions park the FSM
// in TRAP until reset instead of returning to WAIT.
//
// All outputs are Moore: decoded from the state register and the class
// register latched while leaving DECODE.

module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       waiting,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A
`ifdef CPU_CTRL_TRAP_EN
  , output logic     illegal
`endif
);

  state_t       state_q, state_d;
  instr_class_t class_q, dec_class;

  cpu_ctrl_decode u_decode (
    .opcode (opcode),
    .op     (op),
    .cls    (dec_class)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT;
      class_q <= CLS_ILLEGAL;
    end else begin
      state_q <= state_d;
      // Capture the class on the edge leaving DECODE; later states never
      // look at opcode/op again, so the instruction may change underneath.
      if (state_q == S_DECODE) class_q <= dec_class;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d   = state_q;
    waiting   = 1'b0;
    reg_sel   = REG_SEL_RM;
    wb_sel    = WB_SEL_C;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
`ifdef CPU_CTRL_TRAP_EN
    illegal   = 1'b0;
`endif

    case (state_q)
      S_WAIT: begin
        waiting = 1'b1;
        if (start) state_d = S_DECODE;
      end

      // DECODE steers on the live decode; the same value is being latched.
      S_DECODE: begin
        case (dec_class)
          CLS_MOV_IMM:                  state_d = S_WR_IMM;
          CLS_MOV_REG, CLS_MVN:         state_d = S_LOAD_B;
          CLS_ADD, CLS_AND, CLS_CMP:    state_d = S_LOAD_A;
`ifdef CPU_CTRL_TRAP_EN
          default:                      state_d = S_TRAP;
`else
          default:                      state_d = S_WAIT;
`endif
        endcase
      end

      S_LOAD_A: begin
        reg_sel = REG_SEL_RN;
        en_A    = 1'b1;
        state_d = S_LOAD_B;
      end

      S_LOAD_B: begin
        reg_sel = REG_SEL_RM;
        en_B    = 1'b1;
        state_d = S_EXEC;
      end

      // MOV reg passes B through with A forced to zero and leaves flags alone.
      S_EXEC: begin
        en_C = 1'b1;
        if (class_q == CLS_MOV_REG) sel_A     = 1'b1;
        else                        en_status = 1'b1;
        state_d = (class_q == CLS_CMP) ? S_WAIT : S_WR_REG;
      end

      S_WR_REG: begin
        reg_sel = REG_SEL_RD;
        wb_sel  = WB_SEL_C;
        w_en    = 1'b1;
        state_d = S_WAIT;
      end

      S_WR_IMM: begin
        reg_sel = REG_SEL_RN;
        wb_sel  = WB_SEL_IMM;
        w_en    = 1'b1;
        state_d = S_WAIT;
      end

`ifdef CPU_CTRL_TRAP_EN
      // Only rst leaves TRAP, so a state-decoded flag is already sticky.
      S_TRAP: begin
        illegal = 1'b1;
      end
`endif

      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl -- directed self-checking bench for cpu_ctrl.
//
// Each scenario task drives stimulus and compares the packed output vector
// against hand-derived per-edge expectations. Outputs are sampled 1 time
// unit after the rising edge; inputs change at the same point.

module tb_cpu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       waiting;
  logic [1:0] reg_sel;
  logic [1:0] wb_sel;
  logic       w_en, en_A, en_B, en_C, en_status, sel_A;
`ifdef CPU_CTRL_TRAP_EN
  logic       illegal;
`endif

  int n_pass  = 0;
  int n_total = 0;

  cpu_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .opcode    (opcode),
    .op        (op),
    .waiting   (waiting),
    .reg_sel   (reg_sel),
    .wb_sel    (wb_sel),
    .w_en      (w_en),
    .en_A      (en_A),
    .en_B      (en_B),
    .en_C      (en_C),
    .en_status (en_status),
    .sel_A     (sel_A)
`ifdef CPU_CTRL_TRAP_EN
    , .illegal (illegal)
`endif
  );

  always #5 clk = ~clk;

  // Packed view: {waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A}
  localparam logic [10:0] O_WAIT   = 11'b1_00_00_000000;
  localparam logic [10:0] O_DEC    = 11'b0_00_00_000000;
  localparam logic [10:0] O_LDA    = 11'b0_10_00_010000;
  localparam logic [10:0] O_LDB    = 11'b0_00_00_001000;
  localparam logic [10:0] O_EXMOV  = 11'b0_00_00_000101;
  localparam logic [10:0] O_EXALU  = 11'b0_00_00_000110;
  localparam logic [10:0] O_WRREG  = 11'b0_01_00_100000;
  localparam logic [10:0] O_WRIMM  = 11'b0_10_10_100000;
  localparam logic [10:0] O_TRAP   = 11'b0_00_00_000000;

  function automatic logic [10:0] outs();
    return {waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch: start high for exactly the one edge that samples it (edge 1).
  task automatic launch(input logic [2:0] opc, input logic [1:0] o);
    opcode = opc;
    op     = o;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; opcode = 3'b000; op = 2'b00;
    step();
    rst = 1'b0;
    n_total++;
    if (outs() !== O_WAIT) $display("FAIL reset_outs: got %b want %b", outs(), O_WAIT);
    else n_pass++;
`ifdef CPU_CTRL_TRAP_EN
    n_total++;
    if (illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", illegal);
    else n_pass++;
`endif
    step();
    n_total++;
    if (outs() !== O_WAIT) $display("FAIL idle_hold: got %b want %b", outs(), O_WAIT);
    else n_pass++;
  endtask

  task automatic test_mov_imm();
    logic [10:0] exp_v [3] = '{O_DEC, O_WRIMM, O_WAIT};
    launch(3'b110, 2'b10);
    for (int e = 0; e < 3; e++) begin
      if (e > 0) step();
      n_total++;
      if (outs() !== exp_v[e])
        $display("FAIL mov_imm_edge%0d: got %b want %b", e + 1, outs(), exp_v[e]);
      else n_pass++;
    end
  endtask

  task automatic test_mov_reg();
    logic [10:0] exp_v [5] = '{O_DEC, O_LDB, O_EXMOV, O_WRREG, O_WAIT};
    launch(3'b110, 2'b00);
    for (int e = 0; e < 5; e++) begin
      if (e > 0) step();
      n_total++;
      if (outs() !== exp_v[e])
        $display("FAIL mov_reg_edge%0d: got %b want %b", e + 1, outs(), exp_v[e]);
      else n_pass++;
    end
  endtask

  task automatic test_add_and(input logic [1:0] o, input string name);
    logic [10:0] exp_v [6] = '{O_DEC, O_LDA, O_LDB, O_EXALU, O_WRREG, O_WAIT};
    launch(3'b101, o);
    for (int e = 0; e < 6; e++) begin
      if (e > 0) step();
      n_total++;
      if (outs() !== exp_v[e])
        $display("FAIL %s_edge%0d: got %b want %b", name, e + 1, outs(), exp_v[e]);
      else n_pass++;
    end
  endtask

  // CMP, with opcode rewritten after edge 2: 110/01 would be illegal if re-decoded.
  task automatic test_cmp();
    logic [10:0] exp_v [5] = '{O_DEC, O_LDA, O_LDB, O_EXALU, O_WAIT};
    bit saw_wen = 1'b0;
    launch(3'b101, 2'b01);
    for (int e = 0; e < 5; e++) begin
      if (e > 0) step();
      if (e == 1) opcode = 3'b110;
      if (w_en) saw_wen = 1'b1;
      n_total++;
      if (outs() !== exp_v[e])
        $display("FAIL cmp_edge%0d: got %b want %b", e + 1, outs(), exp_v[e]);
      else n_pass++;
    end
    n_total++;
    if (saw_wen !== 1'b0) $display("FAIL cmp_no_wen: got %b want 0", saw_wen);
    else n_pass++;
    opcode = 3'b000;
  endtask

  // MVN; start pulsed mid-flight with a different instruction must be ignored.
  task automatic test_mvn_start_ignored();
    logic [10:0] exp_v [5] = '{O_DEC, O_LDB, O_EXALU, O_WRREG, O_WAIT};
    launch(3'b101, 2'b11);
    for (int e = 0; e < 5; e++) begin
      if (e > 0) step();
      if (e == 1) begin start = 1'b1; opcode = 3'b110; op = 2'b10; end
      if (e == 2) start = 1'b0;
      n_total++;
      if (outs() !== exp_v[e])
        $display("FAIL mvn_edge%0d: got %b want %b", e + 1, outs(), exp_v[e]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_v [8] = '{O_DEC, O_WRIMM, O_WAIT, O_DEC, O_LDA, O_LDB, O_EXALU, O_WAIT};
    launch(3'b110, 2'b10);
    for (int e = 0; e < 8; e++) begin
      if (e > 0) step();
      // Re-arm start as soon as WAIT is reached so edge 4 launches CMP.
      if (e == 2) begin start = 1'b1; opcode = 3'b101; op = 2'b01; end
      if (e == 3) start = 1'b0;
      n_total++;
      if (outs() !== exp_v[e])
        $display("FAIL b2b_edge%0d: got %b want %b", e + 1, outs(), exp_v[e]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit saw_wen = 1'b0;
    launch(3'b101, 2'b00);
    step();                     // edge 2: LOAD_A
    rst = 1'b1;
    step();                     // edge 3: reset taken
    rst = 1'b0;
    n_total++;
    if (outs() !== O_WAIT) $display("FAIL rst_mid: got %b want %b", outs(), O_WAIT);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (w_en || !waiting) saw_wen = 1'b1;
    end
    n_total++;
    if (saw_wen !== 1'b0) $display("FAIL rst_mid_abandon: got %b want 0", saw_wen);
    else n_pass++;
  endtask

  task automatic test_rst_priority();
    opcode = 3'b110; op = 2'b10;
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    n_total++;
    if (outs() !== O_WAIT) $display("FAIL rst_priority: got %b want %b", outs(), O_WAIT);
    else n_pass++;
  endtask

  task automatic test_illegal();
    launch(3'b111, 2'b00);
    n_total++;
    if (outs() !== O_DEC) $display("FAIL illegal_edge1: got %b want %b", outs(), O_DEC);
    else n_pass++;
    step();
`ifdef CPU_CTRL_TRAP_EN
    begin
      bit bad = 1'b0;
      n_total++;
      if (outs() !== O_TRAP || illegal !== 1'b1)
        $display("FAIL trap_entry: got %b/%b want %b/1", outs(), illegal, O_TRAP);
      else n_pass++;
      for (int i = 0; i < 10; i++) begin
        start = 1'b1; step();
        if (waiting !== 1'b0 || illegal !== 1'b1) bad = 1'b1;
        start = 1'b0; step();
        if (waiting !== 1'b0 || illegal !== 1'b1) bad = 1'b1;
      end
      n_total++;
      if (bad !== 1'b0) $display("FAIL trap_hold: got %b want 0", bad);
      else n_pass++;
      rst = 1'b1; step(); rst = 1'b0;
      n_total++;
      if (outs() !== O_WAIT || illegal !== 1'b0)
        $display("FAIL trap_exit: got %b/%b want %b/0", outs(), illegal, O_WAIT);
      else n_pass++;
    end
`else
    n_total++;
    if (outs() !== O_WAIT) $display("FAIL illegal_return: got %b want %b", outs(), O_WAIT);
    else n_pass++;
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; opcode = 3'b000; op = 2'b00;
    test_reset();
    test_mov_imm();
    test_mov_reg();
    test_add_and(2'b00, "add");
    test_add_and(2'b10, "and");
    test_cmp();
    test_mvn_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_rst_priority();
    test_illegal();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
